// File: rtl/dot_seq.sv
// Dot-product sequencer: streams A[i]/B[i] operand pairs into an external MAC and captures the final sum.
// Optional macro DOT_SEQ_STALL_EN adds a stall input that pauses issue while in ISSUE.
module dot_seq #(
    parameter int T_WIDTH = 32,
    parameter int DEPTH   = 16,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LEN_W  = ADDR_W + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic signed [T_WIDTH-1:0] wr_data,
    input  logic                      start,
    input  logic [LEN_W-1:0]          len,
    input  logic [2:0]                mode,
`ifdef DOT_SEQ_STALL_EN
    input  logic                      stall,
`endif
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err,
    output logic signed [T_WIDTH-1:0] res,
    output logic                      res_valid,
    output logic signed [T_WIDTH-1:0] mac_in_1,
    output logic signed [T_WIDTH-1:0] mac_in_2,
    output logic                      mac_in_valid,
    output logic                      mac_reset,
    output logic [2:0]                mac_mode,
    input  logic signed [T_WIDTH-1:0] mac_out,
    input  logic                      mac_out_valid
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

    logic signed [T_WIDTH-1:0] mem_a [DEPTH];
    logic signed [T_WIDTH-1:0] mem_b [DEPTH];

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         idx_q, idx_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [2:0]                mode_q, mode_d;
    logic signed [T_WIDTH-1:0] mac_in_1_q, mac_in_1_d;
    logic signed [T_WIDTH-1:0] mac_in_2_q, mac_in_2_d;
    logic                      mac_in_valid_q, mac_in_valid_d;
    logic                      mac_reset_q, mac_reset_d;
    logic signed [T_WIDTH-1:0] res_q, res_d;
    logic                      res_valid_q, res_valid_d;
    logic                      done_q, done_d;
    logic                      cfg_err_q, cfg_err_d;
    logic                      stall_w;

`ifdef DOT_SEQ_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // NOTE: operand storage has no reset; contents must survive rst so a rerun can reuse them.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == IDLE) begin
            if (wr_sel) mem_b[wr_addr] <= wr_data;
            else        mem_a[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves a variable unassigned (no latches).
        state_d        = state_q;
        idx_d          = idx_q;
        len_d          = len_q;
        mode_d         = mode_q;
        mac_in_1_d     = mac_in_1_q;
        mac_in_2_d     = mac_in_2_q;
        mac_in_valid_d = 1'b0;
        mac_reset_d    = 1'b0;
        res_d          = res_q;
        res_valid_d    = 1'b0;
        done_d         = 1'b0;
        cfg_err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0 && len <= MAX_LEN) begin
                        len_d   = len;
                        mode_d  = mode;
                        idx_d   = '0;
                        state_d = ISSUE;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!stall_w) begin
                    mac_in_1_d     = mem_a[idx_q];
                    mac_in_2_d     = mem_b[idx_q];
                    mac_in_valid_d = 1'b1;
                    mac_reset_d    = (idx_q == '0);
                    idx_d          = idx_q + 1'b1;
                    if ({1'b0, idx_q} == len_q - 1'b1) state_d = WAIT;
                end
            end
            WAIT: begin
                // The first WAIT cycle still sees the result of the next-to-last element; skip it.
                if (mac_out_valid && !mac_in_valid_q) begin
                    res_d       = mac_out;
                    res_valid_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            len_q          <= '0;
            mode_q         <= '0;
            mac_in_1_q     <= '0;
            mac_in_2_q     <= '0;
            mac_in_valid_q <= 1'b0;
            mac_reset_q    <= 1'b0;
            res_q          <= '0;
            res_valid_q    <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            len_q          <= len_d;
            mode_q         <= mode_d;
            mac_in_1_q     <= mac_in_1_d;
            mac_in_2_q     <= mac_in_2_d;
            mac_in_valid_q <= mac_in_valid_d;
            mac_reset_q    <= mac_reset_d;
            res_q          <= res_d;
            res_valid_q    <= res_valid_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    assign busy         = (state_q == ISSUE) || (state_q == WAIT);
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;
    assign res          = res_q;
    assign res_valid    = res_valid_q;
    assign mac_in_1     = mac_in_1_q;
    assign mac_in_2     = mac_in_2_q;
    assign mac_in_valid = mac_in_valid_q;
    assign mac_reset    = mac_reset_q;
    assign mac_mode     = mode_q;

endmodule

// File: tb/tb_dot_seq.sv
// Directed bench for dot_seq with a behavioural integer MAC (one-cycle latency) closing the loop.
// Exercises the stall path too when DOT_SEQ_STALL_EN is defined.
module tb_dot_seq;

    localparam int T_WIDTH = 32;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int LEN_W   = 5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      wr_en;
    logic                      wr_sel;
    logic [ADDR_W-1:0]         wr_addr;
    logic signed [T_WIDTH-1:0] wr_data;
    logic                      start;
    logic [LEN_W-1:0]          len;
    logic [2:0]                mode;
`ifdef DOT_SEQ_STALL_EN
    logic                      stall;
`endif
    logic                      busy, done, cfg_err, res_valid;
    logic signed [T_WIDTH-1:0] res, mac_in_1, mac_in_2, mac_out;
    logic                      mac_in_valid, mac_reset, mac_out_valid;
    logic [2:0]                mac_mode;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_seq #(.T_WIDTH(T_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .mode(mode),
`ifdef DOT_SEQ_STALL_EN
        .stall(stall),
`endif
        .busy(busy), .done(done), .cfg_err(cfg_err), .res(res), .res_valid(res_valid),
        .mac_in_1(mac_in_1), .mac_in_2(mac_in_2), .mac_in_valid(mac_in_valid),
        .mac_reset(mac_reset), .mac_mode(mac_mode),
        .mac_out(mac_out), .mac_out_valid(mac_out_valid)
    );

    // Integer-format MAC: accumulator cleared by mac_reset, result valid one cycle after input.
    logic signed [T_WIDTH-1:0] mac_acc_q;
    logic signed [T_WIDTH-1:0] mac_sum;
    assign mac_sum = (mac_reset ? 32'sd0 : mac_acc_q) + mac_in_1 * mac_in_2;

    always @(posedge clk) begin
        if (rst) begin
            mac_acc_q     <= '0;
            mac_out       <= '0;
            mac_out_valid <= 1'b0;
        end else begin
            mac_out_valid <= mac_in_valid;
            if (mac_in_valid) begin
                mac_acc_q <= mac_sum;
                mac_out   <= mac_sum;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = ADDR_W'(addr);
        wr_data = 32'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_1234_5678();
        for (int i = 0; i < 4; i++) begin
            write(1'b0, i, i + 1);
            write(1'b1, i, i + 5);
        end
    endtask

    // Accept a start, wait (bounded) for res_valid, check latency and result, return in IDLE.
    task automatic run(input int n, input int exp_res, input string tag);
        int lat;
        lat   = 0;
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            tick();
            if (res_valid) lat = c;
        end
        check({tag, "_latency"}, lat, n + 2);
        check({tag, "_res"}, res, exp_res);
        tick();
    endtask

    initial begin
        int hits;
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; len = '0; mode = 3'd0;
`ifdef DOT_SEQ_STALL_EN
        stall = 1'b0;
`endif
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_valid", mac_in_valid, 0);
        check("rst_res", res, 0);
        check("rst_flags", {done, cfg_err, res_valid, mac_reset}, 0);
        rst = 1'b0;
        tick();

        // A=[1,2,3,4] B=[5,6,7,8] len=4, cycle-by-cycle.
        load_1234_5678();
        start = 1'b1; len = 5'd4;
        tick();
        start = 1'b0;
        check("c0_busy", busy, 1);
        check("c0_valid", mac_in_valid, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("issue_valid", mac_in_valid, 1);
            check("issue_a", mac_in_1, k);
            check("issue_b", mac_in_2, k + 4);
            check("issue_reset", mac_reset, (k == 1) ? 1 : 0);
        end
        tick();
        check("c5_valid", mac_in_valid, 0);
        check("c5_res_valid", res_valid, 0);
        tick();
        check("c6_res_valid", res_valid, 1);
        check("c6_done", done, 1);
        check("c6_res", res, 70);
        check("c6_mode", mac_mode, 0);
        tick();
        check("c7_res_valid", res_valid, 0);
        check("c7_done", done, 0);
        check("c7_res_hold", res, 70);
        check("c7_busy", busy, 0);

        // Single element negative, then stale accumulator must be cleared.
        write(1'b0, 0, -3);
        write(1'b1, 0, 7);
        run(1, -21, "neg1");
        write(1'b0, 0, 2); write(1'b0, 1, 2);
        write(1'b1, 0, 3); write(1'b1, 1, 3);
        run(2, 12, "len2");

        // Bad lengths: cfg_err pulse, no activity, mode not latched.
        for (int t = 0; t < 2; t++) begin
            start = 1'b1;
            len   = (t == 0) ? 5'd0 : 5'(DEPTH + 1);
            mode  = 3'd3;
            tick();
            start = 1'b0;
            mode  = 3'd0;
            check("cfg_err_pulse", cfg_err, 1);
            check("cfg_busy", busy, 0);
            tick();
            check("cfg_err_clear", cfg_err, 0);
            check("cfg_no_mac", mac_in_valid, 0);
            check("cfg_mode_kept", mac_mode, 0);
        end

        // start and write during ISSUE are ignored.
        load_1234_5678();
        start = 1'b1; len = 5'd4;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; len = 5'd0;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 32'sd99;
        tick();
        start = 1'b0; wr_en = 1'b0;
        check("busy_start_no_err", cfg_err, 0);
        hits = 0;
        for (int c = 0; c < 40 && hits == 0; c++) begin
            if (res_valid) hits = 1;
            else tick();
        end
        check("busy_ignore_res_valid", hits, 1);
        check("busy_ignore_res", res, 70);
        tick();
        run(1, 5, "a0_kept");

        // Reset mid-run aborts; buffers survive.
        start = 1'b1; len = 5'd4;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", {mac_in_valid, mac_reset}, 0);
        check("abort_ops", mac_in_1 | mac_in_2, 0);
        check("abort_res", res, 0);
        hits = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (res_valid || done || busy) hits++;
        end
        check("abort_quiet", hits, 0);
        run(4, 70, "rerun");

`ifdef DOT_SEQ_STALL_EN
        // Stall on cycles 2-3: two gaps, result two cycles later.
        start = 1'b1; len = 5'd4;
        tick();
        start = 1'b0;
        tick();
        check("st_c1_valid", mac_in_valid, 1);
        stall = 1'b1;
        tick();
        check("st_c2_valid", mac_in_valid, 0);
        check("st_c2_hold", mac_in_1, 1);
        tick();
        check("st_c3_valid", mac_in_valid, 0);
        stall = 1'b0;
        tick();
        check("st_c4_a", mac_in_1, 2);
        check("st_c4_reset", mac_reset, 0);
        hits = 0;
        for (int c = 5; c <= 40 && hits == 0; c++) begin
            tick();
            if (res_valid) hits = c;
        end
        check("st_latency", hits, 8);
        check("st_res", res, 70);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
